// File: rtl/mau_pkg.sv
// Shared types and helpers for the mau_matvec matrix-vector engine.
package mau_pkg;

  typedef enum logic [1:0] {StIdle, StLoadVec, StMac, StOut} state_e;

  typedef enum logic {ModeSet, ModeAcc} mode_e;

  // Working width for saturation; covers 2*DATA_W + clog2(DIM) + 1 up to DATA_W = 38.
  localparam int unsigned WIDE_W = 80;

  typedef struct packed {
    logic              ovf;
    logic [WIDE_W-1:0] val;
  } sat_t;

  // Clamp a signed wide value to a w-bit two's complement range; ovf flags a clamp.
  function automatic sat_t sat_trunc(input logic signed [WIDE_W-1:0] x, input int unsigned w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sat_t r;
    hi = $signed((WIDE_W'(1) << (w - 1)) - WIDE_W'(1));
    lo = ~hi;
    r.ovf = (x > hi) || (x < lo);
    if (x > hi) begin
      r.val = hi;
    end else if (x < lo) begin
      r.val = lo;
    end else begin
      r.val = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/mau_mac_lane.sv
// Multiply-accumulate lane: row sum, fixed-point shift, saturation and optional accumulate.
// Build option: MAU_ROUND_NEAREST_EN adds half an LSB before the shift (round half up).
module mau_mac_lane
  import mau_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned DIM       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              first,
  input  logic              mode_acc,
  input  logic [DATA_W-1:0] mat_in,
  input  logic [DATA_W-1:0] vec_el,
  input  logic [DATA_W-1:0] y_old,
  output logic [DATA_W-1:0] y_new,
  output logic              row_ovf
);

  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(DIM);

`ifdef MAU_ROUND_NEAREST_EN
  localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (FRAC_BITS - 1);
`else
  localparam logic [ACC_W:0] RND = '0;
`endif

  logic        [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    acc_q, acc_d;
  logic        [ACC_W:0]      acc_ext;
  logic signed [ACC_W:0]      rsum;
  logic signed [ACC_W:0]      rsh;
  logic        [WIDE_W-1:0]   t_wide;
  logic        [WIDE_W-1:0]   s_wide;
  logic        [DATA_W:0]     y_sum;
  sat_t                       row_sat;
  sat_t                       acc_sat;
  logic                       unused_hi;

  // Low 2*DATA_W bits of the product of sign-extended operands are the exact signed product.
  assign prod = {{DATA_W{mat_in[DATA_W-1]}}, mat_in} * {{DATA_W{vec_el[DATA_W-1]}}, vec_el};
  assign acc_d = (first ? '0 : acc_q) + {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};

  assign acc_ext = {acc_d[ACC_W-1], acc_d};
  assign rsum    = $signed(acc_ext + RND);
  assign rsh     = rsum >>> FRAC_BITS;
  assign t_wide  = {{(WIDE_W - ACC_W - 1){rsh[ACC_W]}}, rsh};

  always_comb begin
    row_sat = sat_trunc(t_wide, DATA_W);
    y_sum   = {y_old[DATA_W-1], y_old} +
              {row_sat.val[DATA_W-1], row_sat.val[DATA_W-1:0]};
    s_wide  = {{(WIDE_W - DATA_W - 1){y_sum[DATA_W]}}, y_sum};
    acc_sat = sat_trunc(s_wide, DATA_W);
    y_new   = mode_acc ? acc_sat.val[DATA_W-1:0] : row_sat.val[DATA_W-1:0];
    row_ovf = row_sat.ovf | (mode_acc & acc_sat.ovf);
  end

  assign unused_hi = ^{row_sat.val[WIDE_W-1:DATA_W], acc_sat.val[WIDE_W-1:DATA_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mau_matvec.sv
// Streaming signed fixed-point matrix-vector engine, y = M*v or y += M*v, with saturation.
// Build option: MAU_ROUND_NEAREST_EN selects round-half-up instead of truncation.
module mau_matvec
  import mau_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned DIM       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  input  logic [DATA_W-1:0] vec_in,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DATA_W-1:0] mat_in,
  input  logic              mat_valid,
  output logic              mat_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned      IDX_W    = $clog2(DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [IDX_W-1:0]  vec_idx_q, vec_idx_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] v_q [DIM];
  logic [DATA_W-1:0] y_q [DIM];

  logic              vec_acc, mat_acc, col_last;
  logic [DATA_W-1:0] y_new;
  logic              row_ovf;

  assign vec_acc  = (state_q == StLoadVec) && vec_valid;
  assign mat_acc  = (state_q == StMac) && mat_valid;
  assign col_last = (col_q == LAST_IDX);

  mau_mac_lane #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .DIM      (DIM)
  ) u_lane (
    .clk     (clk),
    .reset   (reset),
    .en      (mat_acc),
    .first   (col_q == '0),
    .mode_acc(mode_q == ModeAcc),
    .mat_in  (mat_in),
    .vec_el  (v_q[col_q]),
    .y_old   (y_q[row_q]),
    .y_new   (y_new),
    .row_ovf (row_ovf)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    vec_idx_d = vec_idx_q;
    col_d     = col_q;
    row_d     = row_q;
    out_idx_d = out_idx_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          ovf_d     = 1'b0;
          vec_idx_d = '0;
          col_d     = '0;
          row_d     = '0;
          out_idx_d = '0;
          state_d   = StLoadVec;
        end
      end
      StLoadVec: begin
        if (vec_valid) begin
          if (vec_idx_q == LAST_IDX) begin
            vec_idx_d = '0;
            state_d   = StMac;
          end else begin
            vec_idx_d = vec_idx_q + 1'b1;
          end
        end
      end
      StMac: begin
        if (mat_valid) begin
          if (col_last) begin
            col_d = '0;
            if (row_ovf) ovf_d = 1'b1;
            if (row_q == LAST_IDX) begin
              row_d   = '0;
              state_d = StOut;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StOut: begin
        if (res_ready) begin
          if (out_idx_q == LAST_IDX) begin
            out_idx_d = '0;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mode_q    <= ModeSet;
      vec_idx_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      out_idx_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      vec_idx_q <= vec_idx_d;
      col_q     <= col_d;
      row_q     <= row_d;
      out_idx_q <= out_idx_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // y[] survives between operations so accumulate mode builds on the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIM; i++) begin
        v_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      if (vec_acc) v_q[vec_idx_q] <= vec_in;
      if (mat_acc && col_last) y_q[row_q] <= y_new;
    end
  end

  assign busy      = (state_q != StIdle);
  assign vec_ready = (state_q == StLoadVec);
  assign mat_ready = (state_q == StMac);
  assign res_valid = (state_q == StOut);
  assign res_data  = y_q[out_idx_q];
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mau_matvec.sv
// Randomised self-checking bench for mau_matvec against an arithmetic reference model.
module tb_mau_matvec;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned DIM       = 2;
  localparam int unsigned N         = DIM * DIM;
  localparam int          BOUND     = 200;

  typedef logic [DATA_W-1:0] vec_t [DIM];
  typedef logic [DATA_W-1:0] mat_t [N];

  logic              clk = 1'b0;
  logic              reset, start, mode, busy;
  logic [DATA_W-1:0] vec_in, mat_in, res_data;
  logic              vec_valid, vec_ready, mat_valid, mat_ready;
  logic              res_valid, res_ready, done, ovf;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] y_ref [DIM];
  logic              ovf_ref;

  always #5 clk = ~clk;

  mau_matvec #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .DIM      (DIM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .busy     (busy),
    .vec_in   (vec_in),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .mat_in   (mat_in),
    .mat_valid(mat_valid),
    .mat_ready(mat_ready),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .done     (done),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint x, output bit clamped);
    longint hi = (longint'(1) <<< (DATA_W - 1)) - 1;
    longint lo = -hi - 1;
    clamped = (x > hi) || (x < lo);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  // Reference: y = sat(M*v >> F) or y = sat(y + sat(M*v >> F)).
  task automatic ref_op(input bit md, input vec_t v, input mat_t m);
    longint s, t;
    bit     cl;
    ovf_ref = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      s = 0;
      for (int c = 0; c < DIM; c++)
        s += longint'($signed(m[r*DIM+c])) * longint'($signed(v[c]));
`ifdef MAU_ROUND_NEAREST_EN
      s += longint'(1) <<< (FRAC_BITS - 1);
`endif
      t = sat(s >>> FRAC_BITS, cl);
      ovf_ref |= cl;
      if (md) begin
        t = sat(longint'($signed(y_ref[r])) + t, cl);
        ovf_ref |= cl;
      end
      y_ref[r] = DATA_W'(t);
    end
  endtask

  // Full operation; called and returns at #1 after a rising edge.
  task automatic run_op(input bit md, input vec_t v, input mat_t m, input bit gaps,
                        input int stall, input bit poke, output vec_t res, output int lat);
    int   k, guard, cyc, dones, stall_left;
    bit   acc, held;
    logic [DATA_W-1:0] held_data;
    ref_op(md, v, m);
    start = 1'b1;
    mode  = md;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    check("ovf_cleared", ovf, 0);
    check("busy_after_start", busy, 1);
    k = 0; guard = 0;
    while (k < DIM && guard < BOUND) begin
      vec_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      vec_in    = v[k];
      mat_valid = poke;
      mat_in    = DATA_W'($urandom);
      @(negedge clk);
      acc = vec_valid && vec_ready;
      @(posedge clk); #1;
      cyc++; guard++;
      if (acc) k++;
    end
    if (guard >= BOUND) check("vec_timeout", guard, 0);
    k = 0; guard = 0;
    while (k < N && guard < BOUND) begin
      mat_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      mat_in    = m[k];
      vec_valid = poke;
      vec_in    = DATA_W'($urandom);
      start     = poke && (k == 1);
      mode      = poke ? ~md : md;
      @(negedge clk);
      acc = mat_valid && mat_ready;
      @(posedge clk); #1;
      cyc++; guard++;
      if (acc) k++;
    end
    if (guard >= BOUND) check("mat_timeout", guard, 0);
    vec_valid = 1'b0; mat_valid = 1'b0; start = 1'b0;
    guard = 0;
    while (!res_valid && guard < BOUND) begin
      @(posedge clk); #1;
      cyc++; guard++;
    end
    if (guard >= BOUND) check("res_valid_timeout", guard, 0);
    lat = cyc;
    k = 0; guard = 0; dones = 0; held = 1'b0; held_data = '0; stall_left = stall;
    while (k < DIM && guard < BOUND) begin
      if (stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      dones += int'(done);
      if (res_valid) begin
        if (held) check("res_stable", res_data, held_data);
        held      = !res_ready;
        held_data = res_data;
        if (res_ready) begin
          check($sformatf("res%0d", k), res_data, y_ref[k]);
          res[k] = res_data;
          k++;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= BOUND) check("res_timeout", guard, 0);
    res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      dones += int'(done);
      @(posedge clk); #1;
    end
    check("done_pulses", dones, 1);
    check("ovf", ovf, ovf_ref);
    check("idle_after", busy, 0);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    if ($urandom_range(0, 2) != 0) return DATA_W'(int'($urandom_range(0, 2047)) - 1024);
    return DATA_W'($urandom);
  endfunction

  initial begin
    vec_t v, res;
    mat_t m;
    int   lat;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    vec_in = '0; vec_valid = 1'b0; mat_in = '0; mat_valid = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < DIM; i++) y_ref[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", {vec_ready, mat_ready, res_valid, done}, 0);
    check("rst_ovf", ovf, 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic overwrite
    v = '{16'h0200, 16'h0100};
    m = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    run_op(1'b0, v, m, 1'b0, 0, 1'b0, res, lat);
    check("basic_y0", res[0], 16'h0400);
    check("basic_y1", res[1], 16'hFE80);
    check("basic_lat", lat, 1 + DIM + N);
    check("basic_ovf", ovf, 0);

    // Accumulate onto previous result
    run_op(1'b1, v, m, 1'b0, 0, 1'b0, res, lat);
    check("acc_y0", res[0], 16'h0800);
    check("acc_y1", res[1], 16'hFD00);

    // Saturation
    v = '{16'h7FFF, 16'h7FFF};
    m = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_op(1'b0, v, m, 1'b0, 0, 1'b0, res, lat);
    check("sat_y0", res[0], 16'h7FFF);
    check("sat_y1", res[1], 16'h7FFF);
    check("sat_ovf", ovf, 1);

    // Rounding boundary; start also clears the sticky ovf
    v = '{16'h0080, 16'h0000};
    m = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    run_op(1'b0, v, m, 1'b0, 0, 1'b0, res, lat);
`ifdef MAU_ROUND_NEAREST_EN
    check("round_y0", res[0], 16'h0001);
`else
    check("round_y0", res[0], 16'h0000);
`endif
    check("round_ovf", ovf, 0);

    // Gaps, result backpressure, stray valids and start while busy
    v = '{16'h0200, 16'h0100};
    m = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    run_op(1'b0, v, m, 1'b1, 3, 1'b1, res, lat);
    check("stall_y0", res[0], 16'h0400);
    check("stall_y1", res[1], 16'hFE80);

    // Reset in the middle of MAC after a saturating row completes
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    vec_valid = 1'b1; vec_in = 16'h7FFF;
    repeat (DIM) @(posedge clk);
    #1;
    vec_valid = 1'b0; mat_valid = 1'b1; mat_in = 16'h7FFF;
    repeat (2) @(posedge clk);
    #1;
    mat_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ready", {vec_ready, mat_ready, res_valid, done}, 0);
    check("midrst_ovf", ovf, 0);
    for (int i = 0; i < DIM; i++) y_ref[i] = '0;
    v = '{16'h0200, 16'h0100};
    m = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    run_op(1'b1, v, m, 1'b0, 0, 1'b0, res, lat);
    check("midrst_y0", res[0], 16'h0400);
    check("midrst_y1", res[1], 16'hFE80);

    // Randomised operations
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < DIM; i++) v[i] = rand_word();
      for (int i = 0; i < N; i++) m[i] = rand_word();
      run_op(1'($urandom_range(0, 1)), v, m, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), res, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
